mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences data-memory accesses for the MEM stage. Sits between the EX/MEM pipeline register and
//  a multi-cycle data memory that uses a req/ack handshake. Latches the EX/MEM access, drives the
//  handshake, stalls the pipeline until the access completes, and aborts on timeout or illegal
//  control, reporting the abort on err_o.
// PARAMETERS
//  ADDR_W   32  address width (from ALUResult)
//  DATA_W   32  data width
//  TIMEOUT  16  max cycles in REQ without ack before abort (>=1)
//  TO_W     5   timeout counter width, must hold TIMEOUT
// PORTS
//  clk_i          in   1       clock, all state on rising edge
//  start_i        in   1       reset, synchronous, active-low
//  MemRead_i      in   1       EX/MEM load request
//  MemWrite_i     in   1       EX/MEM store request
//  ALUResult_i    in   ADDR_W  access address
//  RDData_i       in   DATA_W  store data
//  mem_req_o      out  1       memory request, held until ack
//  mem_we_o       out  1       1=write, 0=read; valid with mem_req_o
//  mem_addr_o     out  ADDR_W  latched address
//  mem_wdata_o    out  DATA_W  latched store data
//  mem_ack_i      in   1       memory completion strobe, 1 cycle
//  mem_rdata_i    in   DATA_W  read data, valid with mem_ack_i on reads
//  stall_o        out  1       hold IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
//  rdata_o        out  DATA_W  captured load data
//  rdata_valid_o  out  1       1-cycle pulse, rdata_o valid (loads only)
//  err_o          out  1       1-cycle pulse, access aborted
// BEHAVIOUR
//  Reset (start_i=0 at edge): state=IDLE, counter=0; every registered output =0 next cycle.
//   Reset mid-access drops mem_req_o next cycle; a later ack is ignored.
//  States: IDLE, REQ, DONE, ERR (registered, 2-bit).
//  IDLE: MemRead_i XOR MemWrite_i -> latch addr/wdata/we, go REQ.
//   Both asserted -> go ERR, no request. Neither -> stay.
//  REQ: mem_req_o=1, addr/we/wdata stable. mem_ack_i=1 -> go DONE; on a read, capture
//   mem_rdata_i into rdata_o. No ack -> counter+1. Counter reaching TIMEOUT-1 without ack -> ERR.
//   Counter clears on leaving REQ.
//  DONE: rdata_valid_o=1 for reads only, stall_o=0, then always IDLE. Never re-issues: EX/MEM
//   still holds the finished op this cycle.
//  ERR: err_o=1, stall_o=0, rdata_valid_o=0, rdata_o unchanged; then IDLE.
//  stall_o (combinational) = (IDLE & (MemRead_i|MemWrite_i)) | REQ.
//  mem_ack_i outside REQ is ignored, including a late ack after timeout.
//  Latency: op visible cycle 0, req high cycle 1, ack in cycle 1+n -> DONE in cycle 2+n.
//   Minimum stall is 2 cycles.
//  rdata_o holds its value until the next completed read.
// TESTING
//  Read, ack 1st REQ cycle: MemRead=1 addr=0x100, rdata=0xCAFEF00D
//   -> req cyc1, DONE cyc2, rdata_o=0xCAFEF00D, valid 1 cyc, stall cyc0-1.
//  Write, ack after 3 cycles: MemWrite=1 addr=0x40 data=0x1234
//   -> mem_we_o=1, addr/data stable 4 cyc, no rdata_valid, stall 5 cyc.
//  Timeout: TIMEOUT=4, never ack -> req high 4 cyc, err_o pulse, stall drops;
//   ack 2 cycles later ignored.
//  Illegal: MemRead=MemWrite=1 -> no req, err_o 1 cycle after, stall 1 cycle.
//  Back-to-back load then store -> two full handshakes, one IDLE cycle between,
//   no duplicate request.
//  Reset in REQ: start_i=0 one edge -> all outputs 0 next cycle; subsequent ack ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: latches an EX/MEM load/store, runs the req/ack
// handshake, stalls the pipeline meanwhile and reports aborts (timeout/illegal) on err_o.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] RDData_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [TO_W-1:0]   cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // Handshake: mem_req_o rises in the first REQ cycle and stays high, with
  // addr/we/wdata frozen, until the cycle in which mem_ack_i is sampled high.
  // An ack seen in any other state is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (MemRead_i && MemWrite_i)      state_nxt = ERR;
        else if (MemRead_i ^ MemWrite_i)  state_nxt = REQ;
      end
      REQ: begin
        if (mem_ack_i)             state_nxt = DONE;
        else if (cnt == TO_LAST)   state_nxt = ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (MemRead_i ^ MemWrite_i) begin
            we_q    <= MemWrite_i;
            addr_q  <= ALUResult_i;
            wdata_q <= RDData_i;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            cnt <= '0;
            if (!we_q) rdata_q <= mem_rdata_i;
          end else if (cnt == TO_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // DONE/ERR release the stall so the finished op leaves EX/MEM without being re-issued.
  assign stall_o       = ((state == IDLE) && (MemRead_i || MemWrite_i)) || (state == REQ);
  assign mem_req_o     = (state == REQ);
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state == DONE) && !we_q;
  assign err_o         = (state == ERR);
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4): read, write, timeout, illegal op,
// back-to-back load/store and reset during a request.
module tb_mem_access_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] rd_data = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int req_rises = 0;
  logic req_d = 1'b0;
  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .TO_W(5)) dut (
    .clk_i(clk), .start_i(start), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .ALUResult_i(alu_result), .RDData_i(rd_data), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .stall_o(stall), .rdata_o(rdata),
    .rdata_valid_o(rdata_valid), .err_o(err), .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (mem_req && !req_d) req_rises = req_rises + 1;
    req_d = mem_req;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // scoreboard: a completed read must return the oldest expected load data
  task automatic chk_read(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=0x%08h expected=<empty queue>", tag, rdata);
    end else begin
      e = exp_q.pop_front();
      chk(tag, rdata, e);
    end
  endtask

  initial begin
    int rises0;
    int stall_cycles;

    // reset
    start = 1'b0;
    tick(); tick();
    start = 1'b1;
    chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // read, acked in first REQ cycle
    exp_q.push_back(32'hCAFEF00D);
    mem_read = 1'b1; alu_result = 32'h100;
    #1;
    chk("rd_c0_stall", {31'd0, stall}, 32'd1);
    chk("rd_c0_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("rd_c1_req", {31'd0, mem_req}, 32'd1);
    chk("rd_c1_we", {31'd0, mem_we}, 32'd0);
    chk("rd_c1_addr", mem_addr, 32'h100);
    chk("rd_c1_stall", {31'd0, stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("rd_c2_state", {30'd0, dbg_state}, {30'd0, S_DONE});
    chk("rd_c2_valid", {31'd0, rdata_valid}, 32'd1);
    chk_read("rd_c2_rdata");
    chk("rd_c2_stall", {31'd0, stall}, 32'd0);
    chk("rd_c2_req", {31'd0, mem_req}, 32'd0);
    mem_read = 1'b0;
    tick();
    chk("rd_c3_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rd_c3_hold", rdata, 32'hCAFEF00D);

    // write, ack after three waiting cycles
    mem_write = 1'b1; alu_result = 32'h40; rd_data = 32'h1234;
    stall_cycles = 0;
    #1;
    if (stall) stall_cycles++;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr_req", {31'd0, mem_req}, 32'd1);
      chk("wr_we", {31'd0, mem_we}, 32'd1);
      chk("wr_addr", mem_addr, 32'h40);
      chk("wr_wdata", mem_wdata, 32'h1234);
      chk("wr_novalid", {31'd0, rdata_valid}, 32'd0);
      if (stall) stall_cycles++;
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    if (stall) stall_cycles++;
    chk("wr_stall_cycles", stall_cycles, 32'd5);
    chk("wr_done_state", {30'd0, dbg_state}, {30'd0, S_DONE});
    chk("wr_done_novalid", {31'd0, rdata_valid}, 32'd0);
    chk("wr_rdata_hold", rdata, 32'hCAFEF00D);
    mem_write = 1'b0;
    tick();

    // timeout: no ack for TIMEOUT=4 cycles
    mem_read = 1'b1; alu_result = 32'h200;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", {31'd0, mem_req}, 32'd1);
      chk("to_noerr", {31'd0, err}, 32'd0);
      tick();
    end
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_stall", {31'd0, stall}, 32'd0);
    chk("to_novalid", {31'd0, rdata_valid}, 32'd0);
    chk("to_rdata_hold", rdata, 32'hCAFEF00D);
    mem_read = 1'b0;
    tick();
    chk("to_err_pulse", {31'd0, err}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("late_ack_valid", {31'd0, rdata_valid}, 32'd0);
    chk("late_ack_rdata", rdata, 32'hCAFEF00D);

    // illegal: read and write together
    mem_read = 1'b1; mem_write = 1'b1;
    #1;
    chk("ill_c0_stall", {31'd0, stall}, 32'd1);
    chk("ill_c0_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_req", {31'd0, mem_req}, 32'd0);
    chk("ill_stall", {31'd0, stall}, 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
    chk("ill_err_pulse", {31'd0, err}, 32'd0);

    // back-to-back load then store
    rises0 = req_rises;
    exp_q.push_back(32'h11112222);
    mem_read = 1'b1; alu_result = 32'h300;
    tick();
    chk("b2b_ld_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mem_ack = 1'b0;
    chk("b2b_ld_valid", {31'd0, rdata_valid}, 32'd1);
    chk_read("b2b_ld_rdata");
    mem_read = 1'b0; mem_write = 1'b1; alu_result = 32'h304; rd_data = 32'h55AA;
    tick();
    chk("b2b_idle_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("b2b_idle_req", {31'd0, mem_req}, 32'd0);
    chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("b2b_st_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_st_we", {31'd0, mem_we}, 32'd1);
    chk("b2b_st_addr", mem_addr, 32'h304);
    chk("b2b_st_wdata", mem_wdata, 32'h55AA);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b_st_novalid", {31'd0, rdata_valid}, 32'd0);
    mem_write = 1'b0;
    tick();
    tick();
    chk("b2b_req_count", req_rises - rises0, 32'd2);

    // reset while in REQ
    mem_write = 1'b1; alu_result = 32'h500; rd_data = 32'h77;
    tick();
    chk("rr_req", {31'd0, mem_req}, 32'd1);
    start = 1'b0; mem_write = 1'b0;
    tick();
    start = 1'b1;
    chk("rr_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("rr_req", {31'd0, mem_req}, 32'd0);
    chk("rr_we", {31'd0, mem_we}, 32'd0);
    chk("rr_addr", mem_addr, 32'd0);
    chk("rr_wdata", mem_wdata, 32'd0);
    chk("rr_rdata", rdata, 32'd0);
    chk("rr_stall", {31'd0, stall}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_ack = 1'b0;
    chk("rr_ack_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("rr_ack_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rr_ack_rdata", rdata, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
